// File: rtl/sam_pkg.sv
// Shared definitions for the SAM controller: FSM states, control-word bit
// indices and memory geometry. Imported by sam_memory and sam_controller.
package sam_pkg;

    typedef enum logic [3:0] {
        S_RESET,
        S_FETCH0,
        S_FETCH1,
        S_FETCH2,
        S_DECODE,
        S_RD_MEM,
        S_EX_LOAD,
        S_EX_ADD,
        S_ST_MBR,
        S_ST_MEM
    } state_t;

    localparam int B_PC_ABUS   = 21;
    localparam int B_IR_ABUS   = 20;
    localparam int B_MBR_ABUS  = 19;
    localparam int B_RBUS_AC   = 18;
    localparam int B_AC_ALUA   = 17;
    localparam int B_MBUS_ALUB = 16;
    localparam int B_ALU_ADD   = 15;
    localparam int B_ALU_PASSB = 14;
    localparam int B_MAR_ADDR  = 13;
    localparam int B_MBR_DATA  = 12;
    localparam int B_ABUS_IR   = 11;
    localparam int B_ABUS_MAR  = 10;
    localparam int B_MEM_MBR   = 9;
    localparam int B_RBUS_MBR  = 8;
    localparam int B_MBR_MBUS  = 7;
    localparam int B_PC_CLR    = 6;
    localparam int B_PC_INC    = 5;
    localparam int B_ABUS_PC   = 4;
    localparam int B_RW        = 3;
    localparam int B_REQ       = 2;
    localparam int B_AC_RBUS   = 1;
    localparam int B_ALU_RBUS  = 0;

    localparam int CTRL_W      = 22;
    localparam int MEM_DEPTH   = 256;
    localparam int MEM_AW      = $clog2(MEM_DEPTH);
    localparam int MEM_LATENCY = 2;

endpackage

// File: rtl/sam_memory.sv
// 256x16 word memory with a fixed two-cycle access latency.
// Ports: clk, reset (sync, active-high), index (word address), wdata,
//        request, rw (1=read), rdata (valid at latency), busy (WAIT).
import sam_pkg::*;

module sam_memory (
    input  logic              clk,
    input  logic              reset,
    input  logic [MEM_AW-1:0] index,
    input  logic [15:0]       wdata,
    input  logic              request,
    input  logic              rw,
    output logic [15:0]       rdata,
    output logic              busy
);

    localparam logic [1:0] CNT_DONE = 2'(MEM_LATENCY);

    logic [15:0] mem [MEM_DEPTH];
    logic [1:0]  cnt;
    logic        done;

    assign done  = (cnt == CNT_DONE);
    assign busy  = request && !done;
    assign rdata = (done && rw) ? mem[index] : 16'h0000;

    // Counter saturates at the latency while the request is held, so a
    // held read keeps presenting data until the requester drops it.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= 2'd0;
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= 16'h0000;
            end
        end else begin
            if (!request) begin
                cnt <= 2'd0;
            end else if (!done) begin
                cnt <= cnt + 2'd1;
            end
            if (request && !rw && done) begin
                mem[index] <= wdata;
            end
        end
    end

endmodule

// File: rtl/sam_controller.sv
// SAM accumulator-machine controller: fetch/decode/execute FSM producing
// the 22-bit control word b, plus the attached latency-modelled memory.
// Ports: clk, reset, IR15/IR14 (opcode), AC15 (sign), b (control word),
//        ADDRESS_BUS, DATA_BUS, REQUEST, RW, data_out, WAIT.
import sam_pkg::*;

module sam_controller (
    input  logic              clk,
    input  logic              reset,
    input  logic              IR15,
    input  logic              IR14,
    input  logic              AC15,
    output logic [CTRL_W-1:0] b,
    input  logic [15:0]       ADDRESS_BUS,
    input  logic [15:0]       DATA_BUS,
    input  logic              REQUEST,
    input  logic              RW,
    output logic [15:0]       data_out,
    output logic              WAIT
);

    state_t state;
    state_t nxt;

    // Byte address: bit 0 and the bits above the array are don't-care.
    logic unused_addr;
    assign unused_addr = ^{ADDRESS_BUS[15:MEM_AW+1], ADDRESS_BUS[0]};

    sam_memory u_mem (
        .clk     (clk),
        .reset   (reset),
        .index   (ADDRESS_BUS[MEM_AW:1]),
        .wdata   (DATA_BUS),
        .request (REQUEST),
        .rw      (RW),
        .rdata   (data_out),
        .busy    (WAIT)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_RESET;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        b   = '0;
        nxt = state;
        unique case (state)
            S_RESET: begin
                b[B_PC_CLR] = 1'b1;
                nxt         = S_FETCH0;
            end
            S_FETCH0: begin
                b[B_PC_ABUS]  = 1'b1;
                b[B_ABUS_MAR] = 1'b1;
                nxt           = S_FETCH1;
            end
            S_FETCH1, S_RD_MEM: begin
                b[B_MAR_ADDR] = 1'b1;
                b[B_MEM_MBR]  = 1'b1;
                b[B_RW]       = 1'b1;
                b[B_REQ]      = 1'b1;
                if (!WAIT) begin
                    if (state == S_FETCH1) begin
                        nxt = S_FETCH2;
                    end else begin
                        nxt = IR15 ? S_EX_ADD : S_EX_LOAD;
                    end
                end
            end
            S_FETCH2: begin
                b[B_MBR_ABUS] = 1'b1;
                b[B_ABUS_IR]  = 1'b1;
                b[B_PC_INC]   = 1'b1;
                nxt           = S_DECODE;
            end
            S_DECODE: begin
                b[B_IR_ABUS]  = 1'b1;
                b[B_ABUS_MAR] = 1'b1;
                // BRN only loads the PC when the accumulator is negative.
                b[B_ABUS_PC]  = IR15 && IR14 && AC15;
                unique case ({IR15, IR14})
                    2'b00:   nxt = S_RD_MEM;
                    2'b10:   nxt = S_RD_MEM;
                    2'b01:   nxt = S_ST_MBR;
                    default: nxt = S_FETCH0;
                endcase
            end
            S_EX_LOAD: begin
                b[B_RBUS_AC]   = 1'b1;
                b[B_MBUS_ALUB] = 1'b1;
                b[B_ALU_PASSB] = 1'b1;
                b[B_MBR_MBUS]  = 1'b1;
                b[B_ALU_RBUS]  = 1'b1;
                nxt            = S_FETCH0;
            end
            S_EX_ADD: begin
                b[B_RBUS_AC]   = 1'b1;
                b[B_AC_ALUA]   = 1'b1;
                b[B_MBUS_ALUB] = 1'b1;
                b[B_ALU_ADD]   = 1'b1;
                b[B_MBR_MBUS]  = 1'b1;
                b[B_ALU_RBUS]  = 1'b1;
                nxt            = S_FETCH0;
            end
            S_ST_MBR: begin
                b[B_RBUS_MBR] = 1'b1;
                b[B_AC_RBUS]  = 1'b1;
                nxt           = S_ST_MEM;
            end
            S_ST_MEM: begin
                b[B_MAR_ADDR] = 1'b1;
                b[B_MBR_DATA] = 1'b1;
                b[B_REQ]      = 1'b1;
                if (!WAIT) begin
                    nxt = S_FETCH0;
                end
            end
            default: begin
                nxt = S_RESET;
            end
        endcase
    end

endmodule

// File: tb/tb_sam_controller.sv
// Self-checking bench for sam_controller: directed scenarios followed by a
// randomized run compared against a behavioural model of the machine.
module tb_sam_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        IR15, IR14, AC15;
    logic [21:0] b;
    logic [15:0] ADDRESS_BUS, DATA_BUS;
    logic        REQUEST, RW;
    logic [15:0] data_out;
    logic        WAIT;

    int checks = 0;
    int passes = 0;

    sam_controller dut (
        .clk         (clk),
        .reset       (reset),
        .IR15        (IR15),
        .IR14        (IR14),
        .AC15        (AC15),
        .b           (b),
        .ADDRESS_BUS (ADDRESS_BUS),
        .DATA_BUS    (DATA_BUS),
        .REQUEST     (REQUEST),
        .RW          (RW),
        .data_out    (data_out),
        .WAIT        (WAIT)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        REQUEST = 0; RW = 1; ADDRESS_BUS = 0; DATA_BUS = 0;
        IR15 = 0; IR14 = 0; AC15 = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        cyc();
        reset = 0;
        #1;
    endtask

    task automatic goto_decode();
        do_reset();
        cyc(); cyc(); cyc(); cyc();
    endtask

    task automatic test_reset();
        idle();
        do_reset();
        checks++;
        if (b !== 22'h000040) $display("FAIL reset_b got %h want %h", b, 22'h000040);
        else passes++;
        checks++;
        if (WAIT !== 1'b0) $display("FAIL reset_wait got %b want 0", WAIT);
        else passes++;
        checks++;
        if (data_out !== 16'h0) $display("FAIL reset_dout got %h want 0", data_out);
        else passes++;
        cyc();
        checks++;
        if (b !== 22'h200400) $display("FAIL fetch0_b got %h want %h", b, 22'h200400);
        else passes++;
        cyc();
        checks++;
        if (b !== 22'h00220C) $display("FAIL fetch1_b got %h want %h", b, 22'h00220C);
        else passes++;
    endtask

    task automatic test_fetch_wait();
        idle();
        do_reset();
        cyc(); cyc();
        REQUEST = 1;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (b !== 22'h00220C) $display("FAIL fetch_hold_b[%0d] got %h want %h", i, b, 22'h00220C);
            else passes++;
            checks++;
            if (WAIT !== (i < 2)) $display("FAIL fetch_wait[%0d] got %b want %b", i, WAIT, (i < 2));
            else passes++;
            cyc();
        end
        checks++;
        if (b !== 22'h080820) $display("FAIL fetch2_b got %h want %h", b, 22'h080820);
        else passes++;
        REQUEST = 0;
    endtask

    task automatic test_mem_rw();
        idle();
        do_reset();
        ADDRESS_BUS = 16'h0004; DATA_BUS = 16'h1234; RW = 0; REQUEST = 1;
        cyc(); cyc();
        checks++;
        if (WAIT !== 1'b0) $display("FAIL wr_wait got %b want 0", WAIT);
        else passes++;
        checks++;
        if (data_out !== 16'h0) $display("FAIL wr_dout got %h want 0", data_out);
        else passes++;
        cyc();
        REQUEST = 0;
        cyc();
        RW = 1; REQUEST = 1;
        #1;
        checks++;
        if (data_out !== 16'h0) $display("FAIL rd_early got %h want 0", data_out);
        else passes++;
        cyc(); cyc();
        checks++;
        if (data_out !== 16'h1234) $display("FAIL rd_4 got %h want 1234", data_out);
        else passes++;
        ADDRESS_BUS = 16'h0005;
        #1;
        checks++;
        if (data_out !== 16'h1234) $display("FAIL rd_5 got %h want 1234", data_out);
        else passes++;
        REQUEST = 0;
        cyc();
    endtask

    task automatic test_brn();
        idle();
        goto_decode();
        IR15 = 1; IR14 = 1; AC15 = 1;
        #1;
        checks++;
        if (b !== 22'h100410) $display("FAIL brn_taken got %h want %h", b, 22'h100410);
        else passes++;
        cyc();
        checks++;
        if (b !== 22'h200400) $display("FAIL brn_next got %h want %h", b, 22'h200400);
        else passes++;
        AC15 = 0;
        cyc(); cyc(); cyc();
        checks++;
        if (b !== 22'h100400) $display("FAIL brn_not got %h want %h", b, 22'h100400);
        else passes++;
        cyc();
        checks++;
        if (b !== 22'h200400) $display("FAIL brn_not_next got %h want %h", b, 22'h200400);
        else passes++;
    endtask

    task automatic test_store();
        idle();
        goto_decode();
        IR14 = 1;
        #1;
        checks++;
        if (b !== 22'h100400) $display("FAIL st_decode got %h want %h", b, 22'h100400);
        else passes++;
        cyc();
        checks++;
        if (b !== 22'h000102) $display("FAIL st_mbr got %h want %h", b, 22'h000102);
        else passes++;
        cyc();
        REQUEST = 1; RW = 0; ADDRESS_BUS = 16'h0010; DATA_BUS = 16'hBEEF;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (b !== 22'h003004) $display("FAIL st_mem[%0d] got %h want %h", i, b, 22'h003004);
            else passes++;
            cyc();
        end
        checks++;
        if (b !== 22'h200400) $display("FAIL st_done got %h want %h", b, 22'h200400);
        else passes++;
        REQUEST = 0;
        cyc();
        RW = 1; REQUEST = 1;
        cyc(); cyc();
        checks++;
        if (data_out !== 16'hBEEF) $display("FAIL st_readback got %h want beef", data_out);
        else passes++;
        REQUEST = 0;
        cyc();
    endtask

    task automatic test_reset_mid();
        idle();
        do_reset();
        REQUEST = 1; RW = 0; ADDRESS_BUS = 16'h0008; DATA_BUS = 16'hA5A5;
        cyc(); cyc(); cyc();
        REQUEST = 0; RW = 1;
        cyc();
        checks++;
        if (b !== 22'h100400) $display("FAIL rm_decode got %h want %h", b, 22'h100400);
        else passes++;
        REQUEST = 1;
        cyc();
        checks++;
        if (b !== 22'h00220C) $display("FAIL rm_rdmem got %h want %h", b, 22'h00220C);
        else passes++;
        cyc();
        checks++;
        if (data_out !== 16'hA5A5) $display("FAIL rm_data got %h want a5a5", data_out);
        else passes++;
        reset = 1; REQUEST = 0;
        cyc();
        checks++;
        if (b !== 22'h000040) $display("FAIL rm_b got %h want %h", b, 22'h000040);
        else passes++;
        checks++;
        if (WAIT !== 1'b0) $display("FAIL rm_wait got %b want 0", WAIT);
        else passes++;
        reset = 0; REQUEST = 1; RW = 1;
        cyc(); cyc();
        checks++;
        if (data_out !== 16'h0) $display("FAIL rm_cleared got %h want 0", data_out);
        else passes++;
        REQUEST = 0;
        cyc();
    endtask

    // Behavioural reference: states by name, memory as a plain array,
    // latency as a saturating integer.
    function automatic logic [21:0] model_b(string s, logic i15, logic i14, logic ac);
        if (s == "RESET")   return 22'h000040;
        if (s == "FETCH0")  return 22'h200400;
        if (s == "FETCH1")  return 22'h00220C;
        if (s == "RD_MEM")  return 22'h00220C;
        if (s == "FETCH2")  return 22'h080820;
        if (s == "DECODE")  return (i15 && i14 && ac) ? 22'h100410 : 22'h100400;
        if (s == "EX_LOAD") return 22'h054081;
        if (s == "EX_ADD")  return 22'h078081;
        if (s == "ST_MBR")  return 22'h000102;
        return 22'h003004;
    endfunction

    function automatic string model_next(string s, logic w, logic i15, logic i14);
        if (s == "RESET")  return "FETCH0";
        if (s == "FETCH0") return "FETCH1";
        if (s == "FETCH1") return w ? "FETCH1" : "FETCH2";
        if (s == "FETCH2") return "DECODE";
        if (s == "DECODE") begin
            if (i15 && i14) return "FETCH0";
            if (i14)        return "ST_MBR";
            return "RD_MEM";
        end
        if (s == "RD_MEM") return w ? "RD_MEM" : (i15 ? "EX_ADD" : "EX_LOAD");
        if (s == "ST_MBR") return "ST_MEM";
        if (s == "ST_MEM") return w ? "ST_MEM" : "FETCH0";
        return "FETCH0";
    endfunction

    task automatic test_random();
        string       mst;
        int          mcnt;
        logic [15:0] mm [256];
        logic [21:0] eb;
        logic        ew;
        logic [15:0] ed;
        int          idx;
        mst  = "RESET";
        mcnt = 0;
        idle();
        for (int i = 0; i < 3000; i++) begin
            reset = (i == 0) || ($urandom_range(0, 99) == 0);
            if (REQUEST) begin
                REQUEST = ($urandom_range(0, 9) != 0);
            end else begin
                REQUEST = $urandom_range(0, 1);
                ADDRESS_BUS = 16'($urandom_range(0, 31));
                RW = $urandom_range(0, 1);
                DATA_BUS = 16'($urandom);
            end
            IR15 = $urandom_range(0, 1);
            IR14 = $urandom_range(0, 1);
            AC15 = $urandom_range(0, 1);
            #1;
            idx = int'(ADDRESS_BUS) / 2 % 256;
            eb = model_b(mst, IR15, IR14, AC15);
            ew = REQUEST && (mcnt != 2);
            ed = (mcnt == 2 && RW) ? mm[idx] : 16'h0;
            if (i > 0) begin
                checks++;
                if (b !== eb) $display("FAIL rnd_b[%0d] got %h want %h", i, b, eb);
                else passes++;
                checks++;
                if (WAIT !== ew) $display("FAIL rnd_wait[%0d] got %b want %b", i, WAIT, ew);
                else passes++;
                checks++;
                if (data_out !== ed) $display("FAIL rnd_dout[%0d] got %h want %h", i, data_out, ed);
                else passes++;
            end
            if (reset) begin
                mst  = "RESET";
                mcnt = 0;
                for (int k = 0; k < 256; k++) mm[k] = 16'h0;
            end else begin
                if (REQUEST && !RW && mcnt == 2) mm[idx] = DATA_BUS;
                mst  = model_next(mst, ew, IR15, IR14);
                mcnt = REQUEST ? ((mcnt < 2) ? mcnt + 1 : 2) : 0;
            end
            cyc();
        end
        reset = 0;
        idle();
    endtask

    initial begin
        reset = 1;
        idle();
        cyc();
        test_reset();
        test_fetch_wait();
        test_mem_rw();
        test_brn();
        test_store();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
